// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - request/response sequencer driving the ALU16 Control_Unit
// Accepts one op at a time, pulses start, waits for finish or watchdog abort, returns result.
module alu_issue_ctrl #(
    parameter int          DATA_W  = 16,
    parameter int          TIMEOUT = 64,
    parameter logic [3:0]  OP_MAX  = 4'd3
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [DATA_W-1:0]     req_x,
    input  logic [DATA_W-1:0]     req_y,
    output logic [3:0]            alu_s,
    output logic                  alu_start,
    output logic [DATA_W-1:0]     alu_x,
    output logic [DATA_W-1:0]     alu_y,
    output logic                  alu_clr,
    input  logic                  alu_finish,
    input  logic [2*DATA_W-1:0]   alu_res,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_res,
    output logic [1:0]            rsp_err,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    logic [1:0]          state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [2*DATA_W-1:0] res_q, res_d;
    logic [1:0]          err_q, err_d;
    logic [7:0]          wdog_q, wdog_d;
    logic                timeout_hit;

    assign timeout_hit = (wdog_q == WDOG_LAST);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    x_d  = req_x;
                    y_d  = req_y;
                    if (req_op <= OP_MAX) begin
                        state_d = S_START;
                    end else begin
                        // Illegal ops bypass the CU entirely and answer immediately.
                        state_d = S_RESP;
                        err_d   = ERR_ILLEGAL;
                        res_d   = '0;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
                wdog_d  = '0;
            end
            S_WAIT: begin
                wdog_d = wdog_q + 8'd1;
                // Finish takes priority over a watchdog expiry in the same cycle.
                if (alu_finish) begin
                    state_d = S_RESP;
                    res_d   = alu_res;
                    err_d   = ERR_OK;
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                    res_d   = '0;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    wdog_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            err_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign alu_start = (state_q == S_START);
    assign alu_s     = op_q;
    assign alu_x     = x_q;
    assign alu_y     = y_q;
    // Clear is issued in the expiring WAIT cycle itself so the CU is flushed before RESP.
    assign alu_clr   = (state_q == S_WAIT) && !alu_finish && timeout_hit;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_res   = res_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [15:0] req_x = '0;
    logic [15:0] req_y = '0;
    logic [3:0]  alu_s;
    logic        alu_start;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_clr;
    logic        alu_finish = 1'b0;
    logic [31:0] alu_res = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_res;
    logic [1:0]  rsp_err;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [33:0] sb[$];

    alu_issue_ctrl #(.DATA_W(16), .TIMEOUT(64), .OP_MAX(4'd3)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y),
        .alu_s(alu_s), .alu_start(alu_start), .alu_x(alu_x), .alu_y(alu_y),
        .alu_clr(alu_clr), .alu_finish(alu_finish), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        case (op)
            4'd0:    return {16'h0, x} + {16'h0, y};
            4'd1:    return {16'h0, x} - {16'h0, y};
            4'd2:    return {16'h0, x} * {16'h0, y};
            default: return (y == 16'h0) ? 32'hFFFF_FFFF : {x % y, x / y};
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        req_valid = 1'b1;
        req_op = op;
        req_x = x;
        req_y = y;
        tick(1);
        req_valid = 1'b0;
    endtask

    // CU model: answers from what the DUT presents on alu_s/alu_x/alu_y.
    task automatic pulse_finish();
        alu_res = alu_model(alu_s, alu_x, alu_y);
        alu_finish = 1'b1;
        tick(1);
        alu_finish = 1'b0;
        alu_res = '0;
    endtask

    always @(negedge clk) begin
        if (rst_b && rsp_valid && rsp_ready) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected_rsp: got res=%h err=%0d with nothing expected", rsp_res, rsp_err);
            end else begin
                logic [33:0] exp;
                exp = sb.pop_front();
                if ({rsp_res, rsp_err} !== exp)
                    $display("FAIL sb_rsp: got res=%h err=%0d want res=%h err=%0d", rsp_res, rsp_err, exp[33:2], exp[1:0]);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic test_reset();
        rst_b = 1'b0;
        tick(2);
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else pass_cnt++;
        total_cnt++; if ({alu_start, alu_clr, rsp_valid, busy} !== 4'b0) $display("FAIL rst_ctrl: got %b want 0000", {alu_start, alu_clr, rsp_valid, busy}); else pass_cnt++;
        total_cnt++; if ({alu_s, alu_x, alu_y} !== 36'h0) $display("FAIL rst_alu_bus: got %h want 0", {alu_s, alu_x, alu_y}); else pass_cnt++;
        total_cnt++; if ({rsp_res, rsp_err} !== 34'h0) $display("FAIL rst_rsp: got %h want 0", {rsp_res, rsp_err}); else pass_cnt++;
        rst_b = 1'b1;
        tick(1);
    endtask

    task automatic test_add();
        rsp_ready = 1'b1;
        sb.push_back({alu_model(4'd0, 16'h0003, 16'h0004), 2'd0});
        send_req(4'd0, 16'h0003, 16'h0004);
        total_cnt++; if (alu_start !== 1'b1) $display("FAIL add_start: got %b want 1", alu_start); else pass_cnt++;
        total_cnt++; if (alu_s !== 4'd0) $display("FAIL add_alu_s: got %0d want 0", alu_s); else pass_cnt++;
        total_cnt++; if ({alu_x, alu_y} !== {16'h3, 16'h4}) $display("FAIL add_operands: got %h want 00030004", {alu_x, alu_y}); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL add_ready_start: got %b want 0", req_ready); else pass_cnt++;
        tick(1);
        total_cnt++; if (alu_start !== 1'b0) $display("FAIL add_start_width: got %b want 0", alu_start); else pass_cnt++;
        tick(2);
        total_cnt++; if ({rsp_valid, req_ready, busy} !== 3'b001) $display("FAIL add_wait: got %b want 001", {rsp_valid, req_ready, busy}); else pass_cnt++;
        pulse_finish();
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL add_rsp_valid: got %b want 1", rsp_valid); else pass_cnt++;
        total_cnt++; if ({rsp_res, rsp_err} !== {32'h7, 2'd0}) $display("FAIL add_rsp: got res=%h err=%0d want 7/0", rsp_res, rsp_err); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL add_ready_resp: got %b want 0", req_ready); else pass_cnt++;
        tick(1);
        total_cnt++; if ({rsp_valid, req_ready, busy} !== 3'b010) $display("FAIL add_idle: got %b want 010", {rsp_valid, req_ready, busy}); else pass_cnt++;
    endtask

    task automatic test_mul_stall();
        logic [31:0] exp;
        exp = 32'h0001_FFFE;
        rsp_ready = 1'b0;
        sb.push_back({exp, 2'd0});
        send_req(4'd2, 16'hFFFF, 16'h0002);
        tick(14);
        pulse_finish();
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if ({rsp_valid, busy} !== 2'b11) $display("FAIL mul_stall_valid[%0d]: got %b want 11", i, {rsp_valid, busy}); else pass_cnt++;
            total_cnt++; if ({rsp_res, rsp_err} !== {exp, 2'd0}) $display("FAIL mul_stall_rsp[%0d]: got res=%h err=%0d want %h/0", i, rsp_res, rsp_err, exp); else pass_cnt++;
            total_cnt++; if (alu_s !== 4'd2) $display("FAIL mul_stall_alu_s[%0d]: got %0d want 2", i, alu_s); else pass_cnt++;
            if (i < 4) tick(1);
        end
        rsp_ready = 1'b1;
        tick(1);
        total_cnt++; if ({rsp_valid, busy, req_ready} !== 3'b001) $display("FAIL mul_release: got %b want 001", {rsp_valid, busy, req_ready}); else pass_cnt++;
    endtask

    task automatic test_illegal();
        rsp_ready = 1'b0;
        sb.push_back({32'h0, 2'd1});
        send_req(4'd9, 16'h0005, 16'h0005);
        total_cnt++; if (alu_start !== 1'b0) $display("FAIL ill_start: got %b want 0", alu_start); else pass_cnt++;
        total_cnt++; if ({rsp_valid, rsp_err, rsp_res} !== {1'b1, 2'd1, 32'h0}) $display("FAIL ill_rsp: got v=%b err=%0d res=%h want 1/1/0", rsp_valid, rsp_err, rsp_res); else pass_cnt++;
        rsp_ready = 1'b1;
        tick(1);
        total_cnt++; if ({alu_start, rsp_valid, req_ready} !== 3'b001) $display("FAIL ill_after: got %b want 001", {alu_start, rsp_valid, req_ready}); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int clr_cnt;
        int clr_at;
        clr_cnt = 0;
        clr_at = -1;
        rsp_ready = 1'b1;
        sb.push_back({32'h0, 2'd2});
        send_req(4'd3, 16'h0064, 16'h0007);
        for (int i = 1; i <= 64; i++) begin
            tick(1);
            if (alu_clr === 1'b1) begin
                clr_cnt++;
                if (clr_at < 0) clr_at = i;
            end
        end
        total_cnt++; if (clr_cnt !== 1) $display("FAIL to_clr_count: got %0d want 1", clr_cnt); else pass_cnt++;
        total_cnt++; if (clr_at !== 64) $display("FAIL to_clr_cycle: got %0d want 64", clr_at); else pass_cnt++;
        tick(1);
        total_cnt++; if ({rsp_valid, rsp_err, alu_clr} !== {1'b1, 2'd2, 1'b0}) $display("FAIL to_rsp: got v=%b err=%0d clr=%b want 1/2/0", rsp_valid, rsp_err, alu_clr); else pass_cnt++;
        tick(1);
    endtask

    task automatic test_finish_on_timeout();
        logic [31:0] exp;
        exp = alu_model(4'd3, 16'h0064, 16'h0007);
        rsp_ready = 1'b1;
        sb.push_back({exp, 2'd0});
        send_req(4'd3, 16'h0064, 16'h0007);
        tick(64);
        alu_res = alu_model(alu_s, alu_x, alu_y);
        alu_finish = 1'b1;
        #1;
        total_cnt++; if (alu_clr !== 1'b0) $display("FAIL fot_clr: got %b want 0", alu_clr); else pass_cnt++;
        tick(1);
        alu_finish = 1'b0;
        alu_res = '0;
        total_cnt++; if ({rsp_valid, rsp_err, rsp_res} !== {1'b1, 2'd0, exp}) $display("FAIL fot_rsp: got v=%b err=%0d res=%h want 1/0/%h", rsp_valid, rsp_err, rsp_res, exp); else pass_cnt++;
        tick(1);
    endtask

    task automatic test_back_to_back();
        logic seen;
        rsp_ready = 1'b1;
        sb.push_back({alu_model(4'd1, 16'h000A, 16'h0003), 2'd0});
        send_req(4'd1, 16'h000A, 16'h0003);
        tick(2);
        pulse_finish();
        tick(1);
        sb.push_back({alu_model(4'd3, 16'd100, 16'd7), 2'd0});
        send_req(4'd3, 16'd100, 16'd7);
        total_cnt++; if (alu_start !== 1'b1) $display("FAIL b2b_accept: got %b want 1", alu_start); else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!seen && i == 3) begin
                pulse_finish();
                seen = 1'b1;
            end else begin
                tick(1);
            end
        end
        total_cnt++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL b2b_done: got %b want 00", {rsp_valid, busy}); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        rsp_ready = 1'b1;
        sb.push_back({alu_model(4'd0, 16'h0001, 16'h0002), 2'd0});
        send_req(4'd0, 16'h0001, 16'h0002);
        tick(2);
        rst_b = 1'b0;
        #1;
        total_cnt++; if ({req_ready, alu_start, alu_clr, rsp_valid, busy} !== 5'b10000) $display("FAIL rmw_ctrl: got %b want 10000", {req_ready, alu_start, alu_clr, rsp_valid, busy}); else pass_cnt++;
        total_cnt++; if ({alu_s, alu_x, alu_y, rsp_res, rsp_err} !== 70'h0) $display("FAIL rmw_data: got %h want 0", {alu_s, alu_x, alu_y, rsp_res, rsp_err}); else pass_cnt++;
        void'(sb.pop_back());
        #1;
        rst_b = 1'b1;
        tick(1);
        alu_res = 32'hDEAD_BEEF;
        alu_finish = 1'b1;
        tick(1);
        alu_finish = 1'b0;
        alu_res = '0;
        total_cnt++; if ({rsp_valid, busy, req_ready} !== 3'b001) $display("FAIL rmw_spurious: got %b want 001", {rsp_valid, busy, req_ready}); else pass_cnt++;
        sb.push_back({alu_model(4'd0, 16'h1234, 16'h1111), 2'd0});
        send_req(4'd0, 16'h1234, 16'h1111);
        tick(2);
        pulse_finish();
        total_cnt++; if ({rsp_valid, rsp_res, rsp_err} !== {1'b1, 32'h0000_2345, 2'd0}) $display("FAIL rmw_add: got v=%b res=%h err=%0d want 1/2345/0", rsp_valid, rsp_res, rsp_err); else pass_cnt++;
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_mul_stall();
        test_illegal();
        test_timeout();
        test_finish_on_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        tick(2);
        total_cnt++; if (sb.size() !== 0) $display("FAIL sb_drain: got %0d pending want 0", sb.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Requester-side sequencer for the ALU16 Control_Unit. It accepts operation requests from the instruction stage over a valid/ready handshake and drives the Control_Unit's op select and start pulse, with operands held on the datapath. It waits for finish, then returns the result with a status flag over a second valid/ready handshake. A watchdog aborts operations that never finish.

Parameters:
DATA_W, 16, operand width; result width is 2*DATA_W.
TIMEOUT, 64, maximum cycles in WAIT before abort (range 2..255).
OP_MAX, 4'd3, highest legal op code (0 ADD, 1 SUB, 2 MUL, 3 DIV); codes above it are rejected.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_b  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  4  op code
req_x  in  DATA_W  operand X
req_y  in  DATA_W  operand Y
alu_s  out  4  op select to Control_Unit (s)
alu_start  out  1  start pulse to Control_Unit
alu_x  out  DATA_W  latched operand X to datapath
alu_y  out  DATA_W  latched operand Y to datapath
alu_clr  out  1  one-cycle datapath/CU clear on timeout
alu_finish  in  1  finish from Control_Unit
alu_res  in  2*DATA_W  datapath result, valid in the alu_finish cycle
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_res  out  2*DATA_W  result
rsp_err  out  2  0 ok, 1 illegal op, 2 timeout
busy  out  1  high in any state other than IDLE

Behaviour:
- State machine states: IDLE, START, WAIT, RESP. Reset enters IDLE.
- Reset values: req_ready=1, alu_start=0, alu_clr=0, alu_s=0, alu_x=0, alu_y=0, rsp_valid=0, rsp_res=0, rsp_err=0, busy=0, watchdog=0.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op, x and y.
  - If op<=OP_MAX, go to START.
  - If op>OP_MAX, go to RESP with rsp_err=1, rsp_res=0. alu_start is never asserted for an illegal op.
- START: alu_start=1 for exactly this one cycle. alu_s, alu_x and alu_y already show the latched values. Next state is WAIT unconditionally. alu_finish is ignored in START.
- WAIT: alu_start=0. alu_s, alu_x and alu_y are held stable until the block leaves WAIT. The watchdog increments each cycle.
  - If alu_finish=1: capture alu_res into rsp_res, set rsp_err=0, go to RESP.
  - Else if watchdog reaches TIMEOUT-1: pulse alu_clr for one cycle, set rsp_err=2, rsp_res=0, go to RESP.
  - If finish and timeout occur in the same cycle, finish wins.
- RESP: rsp_valid=1. rsp_res and rsp_err are held stable while rsp_ready=0. When rsp_ready=1, go to IDLE, clear the watchdog, and set rsp_valid=0 in the next cycle.
- Request handling: req_ready=0 in START, WAIT and RESP. There is no skid buffer; there is a single outstanding operation.
- Latency, legal op: accept at edge N; alu_start is high during cycle N..N+1. If finish arrives k cycles after start, rsp_valid rises on the edge after that finish.
- Back-to-back: after RESP is handshaken, the next request can be accepted in the first IDLE cycle, giving one bubble cycle.
- alu_finish outside WAIT: ignored, with no state or output change.
- Asynchronous reset mid-operation:
  - immediately clears all outputs and returns to IDLE;
  - any in-flight result is discarded;
  - alu_clr is not pulsed, because the CU shares rst_b.
- alu_s keeps its last value in IDLE; only alu_start qualifies it.

Test Plan:
- ADD: req op=0, x=16'h0003, y=16'h0004. alu_start high for exactly 1 cycle with alu_s=0. Model asserts finish 3 cycles later with alu_res=32'h7 -> rsp_valid rises the next cycle, rsp_res=32'h7, rsp_err=0, and req_ready=0 throughout.
- MUL with response stall: op=2, x=16'hFFFF, y=16'h0002, finish after 14 cycles with alu_res=32'h0001FFFE. rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_res and rsp_err are stable all 5 cycles, busy=1, alu_s=2 stable; IDLE is reached one cycle after rsp_ready=1.
- Illegal op: op=4'd9 -> no alu_start. RESP is reached the cycle after accept with rsp_err=1 and rsp_res=0.
- Timeout: op=3, finish never asserted, TIMEOUT=64 -> alu_clr is a single-cycle pulse 64 cycles after START, then rsp_err=2.
- Finish on timeout cycle: the model asserts finish exactly on cycle TIMEOUT-1 of WAIT -> rsp_err=0, the result is captured, and alu_clr is never high.
- Reset mid-WAIT and spurious finish: drop rst_b during WAIT -> all outputs take reset values asynchronously, before the next edge. Then pulse alu_finish while in IDLE -> no rsp_valid. A following ADD request completes normally.
